// File: rtl/sdf_ifft_pkg.sv
// Shared types and helpers for the SDF IFFT stage scheduler.
// Stage numbering is 1-based: stage 1 has the longest delay line (NFFT/2).
package sdf_ifft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Delay-line depth of stage s.
    function automatic int stage_delay(input int nfft, input int s);
        return nfft >> s;
    endfunction

    // Count at which stage s sees its first sample of the frame.
    function automatic int stage_offset(input int nfft, input int s, input int pipe);
        return nfft - (32'sd2 * stage_delay(nfft, s)) + ((s - 32'sd1) * pipe);
    endfunction

    // Reverse the low l bits of x; bits at and above l are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int l);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 32'sd0; i < 32'sd32; i++) begin
            if (i < l) begin
                r[i] = x[l - 32'sd1 - i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_ifft_stage_scheduler_slice.sv
// Per-stage control slice: turns the global sample count into this stage's
// butterfly select and twiddle ROM address.
module sdf_stage_ctrl_slice
    import sdf_ifft_pkg::*;
#(
    parameter int NFFT  = 128,
    parameter int PIPE  = 1,
    parameter int STAGE = 1,
    localparam int L    = $clog2(NFFT),
    localparam int CW   = $clog2(2 * NFFT + L * PIPE)
) (
    input  logic [CW-1:0] cnt,
    input  logic          busy,
    output logic          sel,
    output logic [L-2:0]  tw_addr
);

    localparam int OFF = stage_offset(NFFT, STAGE, PIPE);
    localparam logic signed [CW:0] OFF_V  = (CW + 1)'(OFF);
    localparam logic signed [CW:0] NFFT_V = (CW + 1)'(NFFT);

    logic signed [CW:0] loc_s;
    logic               act_s;
    logic               sel_s;
    logic [L-2:0]       tw_s;

    // Position of the current count inside this stage's frame; negative before it starts.
    assign loc_s = $signed({1'b0, cnt}) - OFF_V;
    assign act_s = busy & ~loc_s[CW] & (loc_s < NFFT_V);

    // Select is the stage's half-frame bit; twiddle index is loc mod D scaled to the full-size ROM.
    always_comb begin
        sel_s = act_s & loc_s[L - STAGE];
        tw_s  = {(L - 1){1'b0}};
        if (sel_s) begin
            for (int b = STAGE - 1; b < L - 1; b++) begin
                tw_s[b] = loc_s[b - STAGE + 1];
            end
        end else begin
            tw_s = {(L - 1){1'b0}};
        end
    end

    assign sel     = sel_s;
    assign tw_addr = tw_s;

endmodule

// File: rtl/sdf_ifft_stage_scheduler.sv
// Global sequencer for the radix-2 SDF IFFT pipeline: one sample counter
// drives every stage's control, input acceptance and the output window.
module sdf_ifft_stage_scheduler
    import sdf_ifft_pkg::*;
#(
    parameter int NFFT = 128,
    parameter int PIPE = 1,
    localparam int L   = $clog2(NFFT),
    localparam int TWW = L * (L - 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           in_ready,
    output logic [L-1:0]   sel,
    output logic [TWW-1:0] tw_addr,
    output logic           out_valid,
    output logic [L-1:0]   out_idx,
    output logic [L-1:0]   out_idx_rev,
    output logic           busy,
    output logic           done
);

    localparam int CW   = $clog2(2 * NFFT + L * PIPE);
    localparam int LAT  = NFFT - 1 + L * PIPE;
    localparam int LAST = LAT + NFFT - 1;

    state_e        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          done_r, done_s;
    logic          busy_s;
    logic          out_valid_s;

    // State, counter and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    // Next-state and counter sequencing; abort overrides everything.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                cnt_s = cnt_r + CW'(1);
                if (cnt_r == CW'(NFFT - 1)) begin
                    state_s = FLUSH;
                end else begin
                    state_s = LOAD;
                end
            end
            FLUSH: begin
                if (cnt_r == CW'(LAST)) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    done_s  = 1'b1;
                end else begin
                    state_s = FLUSH;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
        if (abort) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
            done_s  = 1'b0;
        end else begin
            done_s  = done_s;
        end
    end

    assign busy_s      = (state_r != IDLE);
    assign busy        = busy_s;
    assign in_ready    = (state_r == LOAD);
    assign done        = done_r;
    assign out_valid_s = busy_s & (cnt_r >= CW'(LAT)) & (cnt_r < CW'(LAT + NFFT));
    assign out_valid   = out_valid_s;
    assign out_idx     = out_valid_s ? L'(cnt_r - CW'(LAT)) : {L{1'b0}};
    assign out_idx_rev = L'(bitrev(32'(out_idx), L));

    for (genvar s = 1; s <= L; s++) begin : g_stage
        sdf_stage_ctrl_slice #(
            .NFFT (NFFT),
            .PIPE (PIPE),
            .STAGE(s)
        ) u_slice (
            .cnt    (cnt_r),
            .busy   (busy_s),
            .sel    (sel[s-1]),
            .tw_addr(tw_addr[s*(L-1)-1 -: L-1])
        );
    end

endmodule

// File: tb/tb_sdf_ifft_stage_scheduler.sv
// Self-checking bench: a cycle model of the scheduler (NFFT=8, PIPE=1) checks
// every output each cycle, a queue holds the expected reorder addresses, and
// directed sequences check the published timing tables and an NFFT=128 instance.
module tb_sdf_ifft_stage_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0;
    logic       in_ready_a, out_valid_a, busy_a, done_a;
    logic [2:0] sel_a, idx_a, rev_a;
    logic [5:0] tw_a;

    logic        start_b = 1'b0, abort_b = 1'b0;
    logic        in_ready_b, out_valid_b, busy_b, done_b;
    logic [6:0]  sel_b, idx_b, rev_b;
    logic [41:0] tw_b;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sdf_ifft_stage_scheduler #(.NFFT(8), .PIPE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .in_ready(in_ready_a), .sel(sel_a), .tw_addr(tw_a),
        .out_valid(out_valid_a), .out_idx(idx_a), .out_idx_rev(rev_a),
        .busy(busy_a), .done(done_a)
    );

    sdf_ifft_stage_scheduler #(.NFFT(128), .PIPE(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .in_ready(in_ready_b), .sel(sel_b), .tw_addr(tw_b),
        .out_valid(out_valid_b), .out_idx(idx_b), .out_idx_rev(rev_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    int REV_TAB[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int OFF_TAB[3] = '{0, 5, 8};
    int m_state = 0;   // 0 idle, 1 load, 2 flush
    int m_cnt   = 0;
    bit m_done  = 1'b0;
    int exp_q[$];

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 0; m_cnt <= 0; m_done <= 1'b0;
            exp_q.delete();
        end else if (abort_a) begin
            m_state <= 0; m_cnt <= 0; m_done <= 1'b0;
            exp_q.delete();
        end else begin
            case (m_state)
                0: begin
                    m_done <= 1'b0; m_cnt <= 0;
                    if (start_a) begin
                        m_state <= 1;
                        for (int i = 0; i < 8; i++) exp_q.push_back(REV_TAB[i]);
                    end
                end
                1: begin
                    m_done <= 1'b0; m_cnt <= m_cnt + 1;
                    if (m_cnt == 7) m_state <= 2;
                end
                default: begin
                    if (m_cnt == 17) begin
                        m_state <= 0; m_cnt <= 0; m_done <= 1'b1;
                    end else begin
                        m_cnt <= m_cnt + 1; m_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic check_cycle();
        int loc;
        bit mbusy, mvalid;
        logic [2:0] esel;
        logic [5:0] etw;
        mbusy = (m_state != 0);
        esel = 3'd0;
        etw  = 6'd0;
        for (int s = 1; s <= 3; s++) begin
            loc = m_cnt - OFF_TAB[s-1];
            if (mbusy && loc >= 0 && loc < 8 && (((loc >> (3 - s)) & 1) == 1)) begin
                esel[s-1] = 1'b1;
                etw[s*2-1 -: 2] = 2'((loc % (8 >> s)) << (s - 1));
            end
        end
        mvalid = mbusy && m_cnt >= 10 && m_cnt < 18;
        check_val("in_ready", in_ready_a, m_state == 1);
        check_val("busy", busy_a, mbusy);
        check_val("sel", sel_a, esel);
        check_val("tw_addr", tw_a, etw);
        check_val("out_valid", out_valid_a, mvalid);
        check_val("out_idx", idx_a, mvalid ? m_cnt - 10 : 0);
        check_val("done", done_a, m_done);
        if (out_valid_a) begin
            if (exp_q.size() == 0) check_val("rev_q_empty", 1, 0);
            else check_val("out_idx_rev", rev_a, exp_q.pop_front());
        end else begin
            check_val("rev_idle", rev_a, 0);
        end
    endtask

    // Every cycle, compare instance A against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst) check_cycle();
    end

    // ---------------- directed sequences ----------------
    int s0c[$], s0t[$], s1c[$], s1t[$], s2c[$], s2t[$];
    int irdy_n, ov_first, ov_last, ov_n, done_at;
    int E_S0C[4] = '{4, 5, 6, 7};
    int E_S0T[4] = '{0, 1, 2, 3};
    int E_S1C[4] = '{7, 8, 11, 12};
    int E_S1T[4] = '{0, 2, 0, 2};
    int E_S2C[4] = '{9, 11, 13, 15};
    int b_first, b_n, b_done, b_rev0, b_rev1;

    initial begin
        #12 rst = 1'b1;
        @(negedge clk);
        check_val("reset_busy", busy_a, 0);
        check_val("reset_all", {in_ready_a, sel_a, tw_a, out_valid_a, idx_a, rev_a, done_a}, 0);
        chk_en = 1'b1;

        // Single frame with the published schedule tables.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        irdy_n = 0; ov_first = -1; ov_last = -1; ov_n = 0; done_at = -1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready_a) irdy_n++;
            if (sel_a[0]) begin s0c.push_back(c); s0t.push_back(int'(tw_a[1:0])); end
            if (sel_a[1]) begin s1c.push_back(c); s1t.push_back(int'(tw_a[3:2])); end
            if (sel_a[2]) begin s2c.push_back(c); s2t.push_back(int'(tw_a[5:4])); end
            if (out_valid_a) begin
                if (ov_first < 0) ov_first = c;
                ov_last = c; ov_n++;
            end
            if (done_a) done_at = c;
            @(negedge clk);
        end
        check_val("in_ready_n", irdy_n, 8);
        check_val("sel0_n", s0c.size(), 4);
        check_val("sel1_n", s1c.size(), 4);
        check_val("sel2_n", s2c.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < s0c.size()) begin check_val("sel0_cnt", s0c[i], E_S0C[i]); check_val("sel0_tw", s0t[i], E_S0T[i]); end
            if (i < s1c.size()) begin check_val("sel1_cnt", s1c[i], E_S1C[i]); check_val("sel1_tw", s1t[i], E_S1T[i]); end
            if (i < s2c.size()) begin check_val("sel2_cnt", s2c[i], E_S2C[i]); check_val("sel2_tw", s2t[i], 0); end
        end
        check_val("ov_first", ov_first, 10);
        check_val("ov_last", ov_last, 17);
        check_val("ov_n", ov_n, 8);
        check_val("done_at", done_at, 18);

        // Async reset in the middle of a frame.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_val("rst_async", {in_ready_a, sel_a, tw_a, out_valid_a, idx_a, rev_a, busy_a, done_a}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_idle", busy_a, 0);

        // start held high for three frames: one IDLE/done cycle between frames.
        start_a = 1'b1;
        for (int k = 0; k < 57; k++) begin
            @(negedge clk);
            check_val("b2b_busy", busy_a, (k % 19) != 18);
            check_val("b2b_done", done_a, (k % 19) == 18);
        end
        start_a = 1'b0;
        @(negedge clk);
        check_val("b2b_end", busy_a, 0);

        // Abort during LOAD at cnt 3, then restart.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_val("abort_busy", busy_a, 0);
        check_val("abort_sel", sel_a, 0);
        check_val("abort_irdy", in_ready_a, 0);
        check_val("abort_done", done_a, 0);
        @(negedge clk);
        check_val("abort_nodone", done_a, 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_val("restart_irdy", in_ready_a, 1);
        repeat (20) @(negedge clk);

        // abort and start together in IDLE.
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check_val("abort_start_idle", busy_a, 0);
        @(negedge clk);
        check_val("abort_start_idle2", busy_a, 0);
        check_val("q_drain", exp_q.size(), 0);

        // NFFT=128, PIPE=2 instance: output window and done timing.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        b_first = -1; b_n = 0; b_done = -1; b_rev0 = -1; b_rev1 = -1;
        for (int c = 0; c < 400 && b_done < 0; c++) begin
            if (out_valid_b) begin
                if (b_n == 0) begin b_first = c; b_rev0 = int'(rev_b); end
                if (b_n == 1) b_rev1 = int'(rev_b);
                b_n++;
            end
            if (done_b) b_done = c;
            @(negedge clk);
        end
        check_val("b_first_valid", b_first, 141);
        check_val("b_valid_n", b_n, 128);
        check_val("b_done", b_done, 269);
        check_val("b_rev0", b_rev0, 0);
        check_val("b_rev1", b_rev1, 64);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
